// File: rtl/rst_ctrl_pkg.sv
// Shared types and constants for the gated-reset initiator and its timers.
package rst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_WAIT_OK = 2'd2
  } state_e;

  localparam int DEF_PULSE_LEN = 16;
  localparam int DEF_TIMEOUT   = 64;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rst_gate_timer.sv
// Loadable down-counter with a zero flag; load has priority over decrement.
module rst_gate_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rst_gate_ctrl.sv
// Gated-reset initiator: collects requests, holds gated low for PULSE_LEN cycles,
// then waits for the downstream synchronizer's rstn_ok with a timeout.
module rst_gate_ctrl
  import rst_ctrl_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int PULSE_LEN = DEF_PULSE_LEN,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic               rstn_ok,
  output logic               gated,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic [NUM_SRC-1:0] cause,
  output logic [CNT_W-1:0]   rst_count
);

  localparam int PW = cnt_w(PULSE_LEN);
  localparam int TW = cnt_w(TIMEOUT);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN - 1);
  localparam logic [TW-1:0] TMO_LOAD   = TW'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic               gated_q, gated_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               pending_q, pending_d;
  logic [NUM_SRC-1:0] cause_q, cause_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [NUM_SRC-1:0] ereq;
  logic               trig;
  logic               pend_now;
  logic               p_load, p_zero;
  logic               t_load, t_zero;
  logic [PW-1:0]      p_cnt;
  logic [TW-1:0]      t_cnt;

  assign ereq = req & src_en;
  assign trig = |ereq;

  rst_gate_timer #(.W(PW)) u_pulse_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (p_load),
    .load_val (PULSE_LOAD),
    .en       (state_q == ST_ASSERT),
    .cnt      (p_cnt),
    .zero     (p_zero)
  );

  rst_gate_timer #(.W(TW)) u_tmo_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (TMO_LOAD),
    .en       (state_q == ST_WAIT_OK),
    .cnt      (t_cnt),
    .zero     (t_zero)
  );

  always_comb begin
    state_d   = state_q;
    gated_d   = gated_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    pending_d = pending_q;
    cause_d   = cause_q;
    count_d   = count_q;
    p_load    = 1'b0;
    t_load    = 1'b0;
    pend_now  = pending_q | trig;
    case (state_q)
      ST_IDLE: begin
        gated_d   = 1'b1;
        pending_d = 1'b0;
        if (trig) begin
          state_d = ST_ASSERT;
          gated_d = 1'b0;
          cause_d = ereq;
          p_load  = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (trig) begin
          cause_d = cause_q | ereq;
          p_load  = 1'b1;
        end else if (p_zero) begin
          state_d = ST_WAIT_OK;
          gated_d = 1'b1;
          t_load  = 1'b1;
        end
      end
      ST_WAIT_OK: begin
        cause_d   = cause_q | ereq;
        pending_d = pend_now;
        // rstn_ok takes precedence over a same-cycle expiry.
        if (rstn_ok || t_zero) begin
          if (rstn_ok) begin
            done_d  = 1'b1;
            count_d = (count_q == '1) ? count_q : count_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
          pending_d = 1'b0;
          if (pend_now) begin
            state_d = ST_ASSERT;
            gated_d = 1'b0;
            p_load  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gated_d = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gated_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      pending_q <= 1'b0;
      cause_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      gated_q   <= gated_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      pending_q <= pending_d;
      cause_q   <= cause_d;
      count_q   <= count_d;
    end
  end

  assign gated       = gated_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = err_q;
  assign cause       = cause_q;
  assign rst_count   = count_q;

endmodule

// File: tb/tb_rst_gate_ctrl.sv
// Directed bench for rst_gate_ctrl: hand-computed expectations at fixed cycle offsets.
module tb_rst_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] src_en;
  logic       rstn_ok;
  logic       gated, busy, done, timeout_err;
  logic [1:0] cause;
  logic [7:0] rst_count;

  int n_checks = 0;
  int n_errors = 0;

  rst_gate_ctrl #(
    .NUM_SRC   (2),
    .PULSE_LEN (16),
    .TIMEOUT   (64),
    .CNT_W     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .src_en      (src_en),
    .rstn_ok     (rstn_ok),
    .gated       (gated),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .cause       (cause),
    .rst_count   (rst_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full sequence: request, 16-cycle pulse, immediate acknowledge.
  task automatic run_seq();
    req = 2'b01;
    tick();
    req = 2'b00;
    repeat (16) tick();
    rstn_ok = 1'b1;
    tick();
    rstn_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; src_en = 2'b11; rstn_ok = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_gated", gated, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_cause", cause, 0);
    chk("rst_count", rst_count, 0);
    tick();

    // Single request: 16 cycles low, then acknowledge.
    req = 2'b01;
    tick();
    req = 2'b00;
    chk("single_gated_low", gated, 0);
    chk("single_busy", busy, 1);
    chk("single_cause", cause, 2'b01);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("single_hold_low", gated, 0);
    end
    tick();
    chk("single_release", gated, 1);
    chk("single_busy_wait", busy, 1);
    repeat (2) tick();
    rstn_ok = 1'b1;
    tick();
    rstn_ok = 1'b0;
    chk("single_done", done, 1);
    chk("single_count", rst_count, 1);
    chk("single_cause_end", cause, 2'b01);
    chk("single_busy_end", busy, 0);
    tick();
    chk("single_done_pulse", done, 0);

    // Masked request.
    src_en = 2'b01;
    req = 2'b10;
    repeat (3) tick();
    req = 2'b00;
    chk("mask_gated", gated, 1);
    chk("mask_busy", busy, 0);
    chk("mask_cause", cause, 2'b01);
    src_en = 2'b11;

    // Extension: second request 10 cycles in reloads the pulse.
    req = 2'b01;
    tick();
    req = 2'b00;
    repeat (8) tick();
    req = 2'b10;
    tick();
    req = 2'b00;
    tick();
    chk("ext_cause", cause, 2'b11);
    repeat (5) tick();
    chk("ext_still_low", gated, 0);
    rstn_ok = 1'b1;
    tick();
    rstn_ok = 1'b0;
    chk("ext_ok_ignored", done, 0);
    chk("ext_ok_busy", busy, 1);
    repeat (8) tick();
    chk("ext_last_low", gated, 0);
    tick();
    chk("ext_release", gated, 1);

    // Timeout: no acknowledge after release.
    repeat (63) tick();
    chk("tmo_not_yet", timeout_err, 0);
    chk("tmo_busy_before", busy, 1);
    tick();
    chk("tmo_err", timeout_err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_gated", gated, 1);
    chk("tmo_count", rst_count, 1);
    tick();
    chk("tmo_err_pulse", timeout_err, 0);

    // Pending: request during WAIT_OK re-enters ASSERT on acknowledge.
    req = 2'b01;
    tick();
    req = 2'b00;
    repeat (16) tick();
    chk("pend_release", gated, 1);
    req = 2'b10;
    tick();
    req = 2'b00;
    chk("pend_no_reassert", gated, 1);
    chk("pend_cause", cause, 2'b11);
    rstn_ok = 1'b1;
    tick();
    rstn_ok = 1'b0;
    chk("pend_done", done, 1);
    chk("pend_gated_low", gated, 0);
    chk("pend_busy", busy, 1);
    chk("pend_count", rst_count, 2);
    chk("pend_cause_kept", cause, 2'b11);
    repeat (15) tick();
    chk("pend_hold_low", gated, 0);
    tick();
    chk("pend_release2", gated, 1);
    rstn_ok = 1'b1;
    tick();
    rstn_ok = 1'b0;
    chk("pend_done2", done, 1);
    chk("pend_count2", rst_count, 3);
    chk("pend_idle", busy, 0);

    // rstn_ok on the expiry cycle wins.
    req = 2'b01;
    tick();
    req = 2'b00;
    repeat (16) tick();
    repeat (63) tick();
    chk("race_no_err_yet", timeout_err, 0);
    rstn_ok = 1'b1;
    tick();
    rstn_ok = 1'b0;
    chk("race_done", done, 1);
    chk("race_no_err", timeout_err, 0);
    chk("race_count", rst_count, 4);

    // Reset mid-ASSERT aborts.
    req = 2'b01;
    tick();
    req = 2'b00;
    repeat (4) tick();
    chk("abort_pre_low", gated, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_gated", gated, 1);
    chk("abort_busy", busy, 0);
    chk("abort_cause", cause, 0);
    chk("abort_done", done, 0);
    chk("abort_count", rst_count, 0);
    tick();
    chk("abort_no_done", done, 0);
    chk("abort_stays_idle", busy, 0);

    // Saturation of the event counter.
    for (int i = 0; i < 255; i++) run_seq();
    chk("sat_255", rst_count, 255);
    run_seq();
    chk("sat_done", done, 1);
    chk("sat_hold", rst_count, 255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
